mod_mips_multicycle: RTL
========================

MOD_MIPS_MULTICYCLE -- requirements
Module: mod_mips_multicycle

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and reset.
REQ-002 The block SHALL have these parameters:
- RESET_PC, default 32'h0000_0000: PC value loaded at reset.
- MEM_TIMEOUT, default 255: maximum wait cycles for a memory response; 0 disables the timeout.
- TO_W, default 8: timeout counter width.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- instr_req  out  1  instruction fetch request
- instr_addr  out  32  fetch address, equal to pc
- instr_rdata  in  32  fetched instruction
- instr_valid  in  1  instr_rdata is valid this cycle
- data_req  out  1  data access request
- data_we  out  1  1 = store, 0 = load
- data_addr  out  32  ALU result (byte address)
- data_wdata  out  32  store data (rt)
- data_rdata  in  32  load data
- data_valid  in  1  data access complete this cycle
- pc  out  32  current PC register
- halted  out  1  core stopped in HALT
- err_code  out  2  00 none, 01 illegal opcode/funct, 10 instruction timeout, 11 data timeout

Function
REQ-004 The FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-005 FETCH: instr_req=1 and instr_addr=pc. On instr_valid: latch IR, pc<=pc+4, go to DECODE.
REQ-006 DECODE: latch A=rs and B=rt, decode IR.
- j: pc<={pc[31:28],IR[25:0],2'b00}, go to FETCH.
- Unsupported opcode or funct: err_code=01, go to HALT.
- Otherwise go to EXEC.
REQ-007 Supported instructions:
- R-type add(20h), sub(22h), and(24h), or(25h), slt(2Ah, signed).
- addi(08h), lw(23h), sw(2Bh), beq(04h), j(02h).
- Arithmetic is 32-bit wrap-around with no overflow trap.
REQ-008 EXEC: the ALU computes the result into ALUOut.
- The immediate is sign-extended from IR[15:0].
- beq: if A==B then pc<=pc+(sext(imm)<<2), using the already-incremented pc; go to FETCH.
- lw/sw go to MEM; R-type and addi go to WB.
REQ-009 MEM: data_req=1, data_addr=ALUOut, data_we=1 for sw.
- On data_valid: sw goes to FETCH; lw latches data_rdata into MDR and goes to WB.
REQ-010 WB: write the register file.
- R-type writes ALUOut to rd; addi writes ALUOut to rt; lw writes MDR to rt.
- Go to FETCH.
REQ-011 Register 0 SHALL read as 0, and writes to it SHALL be discarded.
REQ-012 Latency with zero-wait memory, counting FETCH cycles:
- j: 2 cycles; beq: 3; R-type, addi and sw: 4; lw: 5.
- Each memory wait cycle adds one cycle.
REQ-013 Request outputs SHALL be registered-state decodes. A request stays asserted with stable address and data until valid, and drops in the cycle after valid.
REQ-014 If valid arrives while the corresponding request is low, it SHALL be ignored.
REQ-015 Timeout: a counter clears on entry to FETCH or MEM and increments each waiting cycle.
- When MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT without valid, set err_code to 10 (FETCH) or 11 (MEM) and go to HALT.
- Valid arriving in the same cycle as the timeout wins.
REQ-016 HALT: all requests are 0, halted=1, and pc and registers are frozen. HALT is left only by reset.

Reset
REQ-017 When reset=1 at a clk edge, the block SHALL set:
- state=FETCH, pc=RESET_PC, err_code=00, halted=0;
- IR, A, B, ALUOut, MDR and the timeout counter to 0;
- all 32 registers to 0.
REQ-018 Reset during a pending request SHALL win. The request is deasserted in the cycle after reset, and the in-flight response is ignored.
REQ-019 While reset is held, instr_req SHALL be 0. The first fetch SHALL occur in the first cycle after reset deasserts.

Structure
REQ-020 A shared package SHALL hold:
- the opcode and funct constants;
- the state encoding;
- the err_code values;
- the ALU operation encoding.
REQ-021 The register file SHALL be the sub-module mod_regfile_2r1w: 32x32, two combinational read ports, one synchronous write port, synchronous reset. The FSM, ALU and PC logic SHALL stay in this module.

Verification
REQ-022 Program addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; sw r3,0(r0) with zero-wait memory -> store of addr 0 and wdata 12 (0x0000000C) 15 cycles after reset release.
REQ-023 Memory preloaded with 0xDEADBEEF at address 8; lw r4,8(r0) then sw r4,4(r0), with data_valid delayed 3 cycles -> the store shows wdata 0xDEADBEEF, and data_req holds stable for 4 cycles.
REQ-024 beq r0,r0,-1 at PC 0x10 -> fetch addresses 0x10,0x10,0x10...; j 0x40 at PC 0x0 -> next fetch address 0x100.
REQ-025 Instruction 0xFC000000 -> halted=1 and err_code=01; instr_req stays 0 afterwards until reset.
REQ-026 MEM_TIMEOUT=4 and instr_valid never asserted -> err_code=10 and halted=1 after 4 wait cycles. Same case with valid in the 4th cycle -> no error.
REQ-027 Reset asserted in the middle of lw, while waiting in MEM -> next fetch at RESET_PC, target register unchanged (0), err_code=00.

Source files
------------

// File: rtl/mod_mips_multicycle_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, functs, FSM states,
// error codes and ALU operations, plus small decode/ALU helpers.
package mod_mips_multicycle_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_ILLEGAL  = 2'b01,
    ERR_INSTR_TO = 2'b10,
    ERR_DATA_TO  = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OP_RTYPE: ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic alu_op_e alu_op_for(input logic [5:0] opcode, input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SUB:  op = ALU_SUB;
        FN_AND:  op = ALU_AND;
        FN_OR:   op = ALU_OR;
        FN_SLT:  op = ALU_SLT;
        default: op = ALU_ADD;
      endcase
    end else if (opcode == OP_BEQ) begin
      op = ALU_SUB;
    end
    return op;
  endfunction

  function automatic logic [31:0] alu_compute(input alu_op_e op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'd0, $signed(a) < $signed(b)};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mod_mips_multicycle_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// Register 0 is hard-wired to zero on both read and write.
module mod_regfile_2r1w
  import mod_mips_multicycle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs_q[raddr_b];

endmodule

// File: rtl/mod_mips_multicycle.sv
// Multicycle MIPS subset core (FETCH/DECODE/EXEC/MEM/WB) with request/valid
// memory handshakes, a shared wait timeout and a sticky HALT on error.
module mod_mips_multicycle
  import mod_mips_multicycle_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 255,
  parameter int          TO_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_rdata,
  input  logic        instr_valid,
  output logic        data_req,
  output logic        data_we,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_valid,
  output logic [31:0] pc,
  output logic        halted,
  output logic [1:0]  err_code
);

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       alu_out_q, alu_out_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, alu_b;
  logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic [4:0]  rf_waddr;
  logic        rf_we;
  logic [TO_W-1:0] to_cnt_inc;
  logic        to_expired;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign alu_b    = (opcode == OP_RTYPE) ? b_q : imm_sext;

  // Valid takes priority over expiry, so a response on the last allowed cycle is accepted.
  assign to_cnt_inc = to_cnt_q + 1'b1;
  assign to_expired = (MEM_TIMEOUT != 0) && (to_cnt_inc == TO_W'(MEM_TIMEOUT));

  mod_regfile_2r1w u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rs),
    .rdata_a (rf_rdata_a),
    .raddr_b (rt),
    .rdata_b (rf_rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    to_cnt_d  = to_cnt_q;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_out_q;

    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = ST_DECODE;
        end else if (to_expired) begin
          err_d   = ERR_INSTR_TO;
          state_d = ST_HALT;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      ST_DECODE: begin
        a_d = rf_rdata_a;
        b_d = rf_rdata_b;
        if (opcode == OP_J) begin
          pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
          to_cnt_d = '0;
          state_d  = ST_FETCH;
        end else if (!is_legal(opcode, funct)) begin
          err_d   = ERR_ILLEGAL;
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_out_d = alu_compute(alu_op_for(opcode, funct), a_q, alu_b);
        // Branch offset is relative to the already-incremented pc.
        if (opcode == OP_BEQ) begin
          if (a_q == b_q) begin
            pc_d = pc_q + (imm_sext << 2);
          end
          to_cnt_d = '0;
          state_d  = ST_FETCH;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          to_cnt_d = '0;
          state_d  = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (data_valid) begin
          if (opcode == OP_LW) begin
            mdr_d   = data_rdata;
            state_d = ST_WB;
          end else begin
            to_cnt_d = '0;
            state_d  = ST_FETCH;
          end
        end else if (to_expired) begin
          err_d   = ERR_DATA_TO;
          state_d = ST_HALT;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      ST_WB: begin
        rf_we = 1'b1;
        if (opcode == OP_RTYPE) begin
          rf_waddr = rd;
        end else if (opcode == OP_LW) begin
          rf_wdata = mdr_q;
        end
        to_cnt_d = '0;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      err_q     <= ERR_NONE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Requests are pure state decodes, held low while reset is asserted.
  assign instr_req  = (state_q == ST_FETCH) && !reset;
  assign instr_addr = pc_q;
  assign data_req   = (state_q == ST_MEM) && !reset;
  assign data_we    = data_req && (opcode == OP_SW);
  assign data_addr  = alu_out_q;
  assign data_wdata = b_q;
  assign pc         = pc_q;
  assign halted     = (state_q == ST_HALT);
  assign err_code   = err_q;

endmodule
